// File: rtl/osd_cmd_sequencer.sv
// osd_cmd_sequencer: buffers OSD command transactions and replays them on the OSD bus with fixed setup/strobe/gap/idle timing
// Ports:
//   clk_sys, reset_n                : single clock, asynchronous active-low reset
//   s_valid, s_ready, s_data, s_last: input word stream; s_last marks the final word of a transaction
//   abort                           : flushes the FIFO and terminates the current transaction
//   io_osd, io_strobe, io_din       : registered OSD bus (transaction frame, word strobe, word data)
//   busy                            : sequencer is not idle
//   level                           : FIFO occupancy
module osd_cmd_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int STROBE_W = 2,
    parameter int GAP_W = 2,
    parameter int IDLE_W = 4
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [15:0]                   s_data,
    input  logic                          s_last,
    input  logic                          abort,
    output logic                          io_osd,
    output logic                          io_strobe,
    output logic [15:0]                   io_din,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SG_W = (STROBE_W > GAP_W) ? STROBE_W : GAP_W;
    localparam int MAX_W = (SG_W > IDLE_W) ? SG_W : IDLE_W;
    localparam int CW = $clog2(MAX_W + 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_W - 1);
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_W - 1);
    localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP, S_WAIT, S_TAIL} state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [16:0] mem [FIFO_DEPTH];
    logic [16:0] head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic empty, full, push, pop, cur_last;
    logic osd_d, strobe_d, last_d;
    logic [15:0] din_d;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full = (level == (AW+1)'(FIFO_DEPTH));
    assign s_ready = ~full & ~abort;
    assign push = s_valid & s_ready;
    assign head = mem[rd_ptr[AW-1:0]];
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
    end

    // abort never coincides with a push, so copying wr_ptr empties the FIFO
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (abort) rd_ptr <= wr_ptr;
            else if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt <= '0;
            cur_last <= 1'b0;
            io_osd <= 1'b0;
            io_strobe <= 1'b0;
            io_din <= '0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
            cur_last <= last_d;
            io_osd <= osd_d;
            io_strobe <= strobe_d;
            io_din <= din_d;
        end
    end

    // cnt holds the remaining cycles of the current timed state minus one
    always_comb begin
        state_next = state;
        cnt_next = (cnt == '0) ? cnt : cnt - 1'b1;
        pop = 1'b0;
        case (state)
            S_IDLE: if (!empty) begin
                pop = 1'b1;
                state_next = S_SETUP;
            end
            S_SETUP: begin
                state_next = S_STROBE;
                cnt_next = STROBE_LD;
            end
            S_STROBE: if (cnt == '0) begin
                state_next = S_GAP;
                cnt_next = GAP_LD;
            end
            S_GAP: if (cnt == '0) begin
                if (cur_last) begin
                    state_next = S_TAIL;
                    cnt_next = IDLE_LD;
                end else if (!empty) begin
                    pop = 1'b1;
                    state_next = S_SETUP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: if (!empty) begin
                pop = 1'b1;
                state_next = S_SETUP;
            end
            S_TAIL: if (cnt == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // a running TAIL keeps its count; IDLE only flushes
        if (abort && state != S_TAIL) begin
            pop = 1'b0;
            state_next = (state == S_IDLE) ? S_IDLE : S_TAIL;
            cnt_next = IDLE_LD;
        end
    end

    // outputs are registered from the next state so they switch together with the state
    always_comb begin
        osd_d = (state_next == S_SETUP) || (state_next == S_STROBE) || (state_next == S_GAP) || (state_next == S_WAIT);
        strobe_d = (state_next == S_STROBE);
        din_d = pop ? head[15:0] : io_din;
        last_d = pop ? head[16] : cur_last;
    end
endmodule
